// File: rtl/sccb_responder.sv
// SCCB slave with a 256x8 register file, standing in for an OV camera sensor on the
// configuration bus. Handles 3-phase writes and 2-phase + 2-phase reads for one device ID.
module sccb_responder #(
    parameter logic [7:0] DEV_ID = 8'h42
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       reg_we,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    input  logic [7:0] dbg_addr,
    output logic [7:0] dbg_data,
    output logic       busy,
    output logic       id_err
);

    typedef enum logic [3:0] {
        IDLE, ID, ID_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RD_ACK, HOLD
    } state_t;

    state_t     state;
    logic [1:0] scl_sync, sda_sync;
    logic       scl_d, sda_d;
    logic       scl_s, sda_s;
    logic       scl_rise, scl_fall, start_cond, stop_cond;
    logic [7:0] regs [256];
    logic [7:0] shift, sub_ptr, rx_byte;
    logic [3:0] cnt;
    logic       rw, wr_en;

    assign scl_s      = scl_sync[1];
    assign sda_s      = sda_sync[1];
    assign scl_rise   = scl_s & ~scl_d;
    assign scl_fall   = ~scl_s & scl_d;
    assign start_cond = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_cond  = scl_s & scl_d & ~sda_d & sda_s;
    assign rx_byte    = {shift[6:0], sda_s};
    assign wr_en      = (state == WDATA) && scl_rise && (cnt == 4'd7);

    // Bus idles high, so the synchronizers reset to 1 to avoid a phantom edge at release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl};
            sda_sync <= {sda_sync[0], sda_in};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    // NOTE: the register file must clear on reset, so it is built from resettable flops
    // rather than a RAM macro; a RAM would keep stale contents across rst.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) regs[i] <= 8'h00;
            dbg_data <= 8'h00;
        end else begin
            dbg_data <= regs[dbg_addr];
            if (wr_en) regs[sub_ptr] <= rx_byte;
        end
    end

    // NOTE: all state here uses non-blocking assignments so every branch sees the
    // pre-edge values of sda_oe, cnt and shift regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            sda_oe    <= 1'b0;
            reg_we    <= 1'b0;
            reg_addr  <= 8'h00;
            reg_wdata <= 8'h00;
            busy      <= 1'b0;
            id_err    <= 1'b0;
            sub_ptr   <= 8'h00;
            shift     <= 8'h00;
            cnt       <= 4'd0;
            rw        <= 1'b0;
        end else begin
            reg_we <= 1'b0;
            if (stop_cond) begin
                state  <= IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else if (start_cond) begin
                state  <= ID;
                sda_oe <= 1'b0;
                busy   <= 1'b1;
                cnt    <= 4'd0;
            end else begin
                case (state)
                    ID: if (scl_rise) begin
                        shift <= rx_byte;
                        cnt   <= cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            cnt <= 4'd0;
                            if (rx_byte[7:1] != DEV_ID[7:1]) begin
                                id_err <= 1'b1;
                                state  <= HOLD;
                            end else begin
                                rw    <= rx_byte[0];
                                state <= ID_ACK;
                            end
                        end
                    end
                    SUB: if (scl_rise) begin
                        shift <= rx_byte;
                        cnt   <= cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            sub_ptr <= rx_byte;
                            state   <= SUB_ACK;
                        end
                    end
                    WDATA: if (scl_rise) begin
                        shift <= rx_byte;
                        cnt   <= cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            reg_we    <= 1'b1;
                            reg_addr  <= sub_ptr;
                            reg_wdata <= rx_byte;
                            state     <= WDATA_ACK;
                        end
                    end
                    // First falling edge drives the ACK low, the second ends the slot.
                    ID_ACK, SUB_ACK, WDATA_ACK: if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe <= 1'b1;
                        end else begin
                            cnt <= 4'd0;
                            if (state == ID_ACK && rw) begin
                                shift  <= regs[sub_ptr];
                                sda_oe <= ~regs[sub_ptr][7];
                                state  <= RDATA;
                            end else begin
                                sda_oe <= 1'b0;
                                if (state == ID_ACK)       state <= SUB;
                                else if (state == SUB_ACK) state <= WDATA;
                                else                       state <= HOLD;
                            end
                        end
                    end
                    RDATA: begin
                        if (scl_rise) cnt <= cnt + 4'd1;
                        if (scl_fall) begin
                            if (cnt == 4'd8) begin
                                sda_oe <= 1'b0;
                                state  <= RD_ACK;
                            end else begin
                                sda_oe <= ~shift[6];
                                shift  <= {shift[6:0], 1'b0};
                            end
                        end
                    end
                    RD_ACK: if (scl_rise) state <= HOLD;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sccb_responder.sv
// Bench for sccb_responder: bit-level SCCB master, directed vector table, corner sequences,
// and randomized transactions checked against a transaction-level register model.
module tb_sccb_responder;

    localparam int Q = 3;  // clk cycles per quarter SCL period (12x ratio)

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic [7:0] dbg_addr = 8'h00;
    logic       sda_oe, reg_we, busy, id_err, sda_bus;
    logic [7:0] reg_addr, reg_wdata, dbg_data;

    assign sda_bus = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    sccb_responder #(.DEV_ID(8'h42)) dut (
        .clk(clk), .rst(rst), .scl(scl), .sda_in(sda_bus), .sda_oe(sda_oe),
        .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .busy(busy), .id_err(id_err)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int we_cnt  = 0;

    always @(negedge clk) if (reg_we === 1'b1) we_cnt++;

    // Reference model: register contents, sub-address pointer and sticky ID error.
    logic [7:0] m_mem [256];
    logic [7:0] m_ptr;
    logic       m_iderr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
        m_ptr   = 8'h00;
        m_iderr = 1'b0;
    endtask

    // Write-direction transaction of n bytes starting with the ID byte.
    task automatic model_write(input logic [7:0] b [4], input int n,
                               output logic [3:0] acks, output int wes);
        acks = 4'b0000;
        wes  = 0;
        if (n < 1) return;
        if (b[0][7:1] != 7'h21) begin
            m_iderr = 1'b1;
            return;
        end
        acks[0] = 1'b1;
        if (n >= 2) begin
            acks[1] = 1'b1;
            m_ptr   = b[1];
        end
        if (n >= 3) begin
            acks[2]      = 1'b1;
            m_mem[m_ptr] = b[2];
            wes          = 1;
        end
    endtask

    task automatic q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_start();
        scl = 1'b0; q(); sda_m = 1'b1; q(); scl = 1'b1; q(); sda_m = 1'b0; q();
    endtask

    task automatic bus_stop();
        scl = 1'b0; q(); sda_m = 1'b0; q(); scl = 1'b1; q(); sda_m = 1'b1; q();
    endtask

    task automatic send_bit(input logic b);
        scl = 1'b0; q(); sda_m = b; q(); scl = 1'b1; q(); q();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        scl = 1'b0; q(); sda_m = 1'b1; q(); scl = 1'b1; q();
        ack = ~sda_bus;
        q();
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        sda_m = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            scl = 1'b0; q(); q(); scl = 1'b1; q();
            d[i] = sda_bus;
            q();
        end
        scl = 1'b0; q(); sda_m = nack; q(); scl = 1'b1; q(); q();
    endtask

    task automatic write_txn(input logic [7:0] b [4], input int n,
                             output logic [3:0] acks, output int wes);
        int   we0;
        logic a;
        we0  = we_cnt;
        acks = 4'b0000;
        bus_start();
        for (int i = 0; i < n; i++) begin
            write_byte(b[i], a);
            acks[i] = a;
        end
        bus_stop();
        repeat (4) @(negedge clk);
        wes = we_cnt - we0;
    endtask

    task automatic read_txn(input logic nack, output logic ack, output logic [7:0] d);
        bus_start();
        write_byte(8'h43, ack);
        read_byte(nack, d);
        bus_stop();
        repeat (4) @(negedge clk);
    endtask

    task automatic dbg_check(input logic [7:0] a, input logic [7:0] e, input string name);
        dbg_addr = a;
        @(negedge clk);
        check(name, dbg_data, e);
    endtask

    typedef struct {
        logic [31:0] bytes;
        int          n;
        logic [3:0]  ack;
        int          we;
        logic [7:0]  addr;
        logic [7:0]  wdata;
        logic        id_err;
    } vec_t;

    initial begin
        vec_t       vecs [5];
        logic [7:0] b [4];
        logic [7:0] bb, d, exp_d;
        logic [3:0] acks, m_acks;
        logic       a;
        int         wes, m_wes, we0, kind, n;

        vecs[0] = '{32'h42128000, 3, 4'b0111, 1, 8'h12, 8'h80, 1'b0};
        vecs[1] = '{32'h420A7600, 3, 4'b0111, 1, 8'h0A, 8'h76, 1'b0};
        vecs[2] = '{32'h60125500, 3, 4'b0000, 0, 8'h0A, 8'h76, 1'b1};
        vecs[3] = '{32'h42201122, 4, 4'b0111, 1, 8'h20, 8'h11, 1'b1};
        vecs[4] = '{32'h42305A00, 3, 4'b0111, 1, 8'h30, 8'h5A, 1'b1};

        model_reset();
        repeat (3) @(negedge clk);
        check("rst sda_oe", sda_oe, 0);
        check("rst reg_we", reg_we, 0);
        check("rst reg_addr", reg_addr, 0);
        check("rst reg_wdata", reg_wdata, 0);
        check("rst dbg_data", dbg_data, 0);
        check("rst busy", busy, 0);
        check("rst id_err", id_err, 0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            b[0] = vecs[v].bytes[31:24];
            b[1] = vecs[v].bytes[23:16];
            b[2] = vecs[v].bytes[15:8];
            b[3] = vecs[v].bytes[7:0];
            write_txn(b, vecs[v].n, acks, wes);
            model_write(b, vecs[v].n, m_acks, m_wes);
            check($sformatf("vec%0d acks", v), acks, vecs[v].ack);
            check($sformatf("vec%0d we pulses", v), wes, vecs[v].we);
            check($sformatf("vec%0d reg_addr", v), reg_addr, vecs[v].addr);
            check($sformatf("vec%0d reg_wdata", v), reg_wdata, vecs[v].wdata);
            check($sformatf("vec%0d id_err", v), id_err, vecs[v].id_err);
            check($sformatf("vec%0d busy idle", v), busy, 0);
        end
        dbg_check(8'h12, 8'h80, "dbg 0x12 kept after bad id");
        dbg_check(8'h0A, 8'h76, "dbg 0x0A");
        dbg_check(8'h20, 8'h11, "dbg 0x20");
        dbg_check(8'h21, 8'h00, "dbg 0x21 no auto-inc");
        dbg_check(8'h30, 8'h5A, "dbg 0x30");

        // 2-phase write to set the pointer, then 2-phase read with NACK.
        b[0] = 8'h42; b[1] = 8'h0A;
        write_txn(b, 2, acks, wes);
        model_write(b, 2, m_acks, m_wes);
        check("ptr set acks", acks, 4'b0011);
        check("ptr set no write", wes, 0);
        bus_start();
        write_byte(8'h43, a);
        check("read id ack", a, 1);
        check("busy mid read", busy, 1);
        read_byte(1'b1, d);
        check("read data 0x0A", d, 8'h76);
        bus_stop();
        repeat (4) @(negedge clk);
        check("busy after read", busy, 0);
        check("sda released after read", sda_oe, 0);

        // Repeated START after the sub-address, no STOP in between.
        b[0] = 8'h42; b[1] = 8'h05; b[2] = 8'hC3;
        write_txn(b, 3, acks, wes);
        model_write(b, 3, m_acks, m_wes);
        b[1] = 8'h07; b[2] = 8'h9E;
        write_txn(b, 3, acks, wes);
        model_write(b, 3, m_acks, m_wes);
        bus_start();
        write_byte(8'h42, a);
        write_byte(8'h05, a);
        check("sr sub ack", a, 1);
        m_ptr = 8'h05;
        bus_start();
        write_byte(8'h43, a);
        check("sr read id ack", a, 1);
        read_byte(1'b1, d);
        check("sr read data", d, 8'hC3);
        bus_stop();
        repeat (4) @(negedge clk);

        // Reset while the responder is pulling SDA low in the ID ACK slot.
        bus_start();
        bb = 8'h42;
        for (int i = 7; i >= 0; i--) send_bit(bb[i]);
        scl = 1'b0; q(); sda_m = 1'b1; q();
        check("ack driven before reset", sda_oe, 1);
        rst = 1'b0;
        #1;
        check("async sda release", sda_oe, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_reset();
        scl = 1'b1; q(); q();
        bus_stop();
        check("id_err cleared by reset", id_err, 0);
        check("reg_addr cleared by reset", reg_addr, 0);
        dbg_check(8'h30, 8'h00, "regs cleared by reset");

        // Reset during the 5th bit of WDATA; the block must ignore the rest of the frame.
        bb = 8'hEE;
        bus_start();
        write_byte(8'h42, a);
        write_byte(8'h01, a);
        for (int i = 7; i >= 4; i--) send_bit(bb[i]);
        we0 = we_cnt;
        scl = 1'b0; q(); sda_m = bb[3]; q(); scl = 1'b1; q();
        rst = 1'b0;
        #1;
        check("sda_oe low in reset", sda_oe, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_reset();
        q();
        for (int i = 2; i >= 0; i--) send_bit(bb[i]);
        scl = 1'b0; q(); sda_m = 1'b1; q(); scl = 1'b1; q();
        a = ~sda_bus;
        q();
        check("no ack after reset", a, 0);
        bus_stop();
        repeat (4) @(negedge clk);
        check("no write after reset", we_cnt - we0, 0);
        dbg_check(8'h01, 8'h00, "reg 0x01 untouched");
        b[0] = 8'h42; b[1] = 8'h01; b[2] = 8'hAB;
        write_txn(b, 3, acks, wes);
        model_write(b, 3, m_acks, m_wes);
        check("post-reset write acks", acks, 4'b0111);
        check("post-reset write we", wes, 1);
        check("post-reset reg_addr", reg_addr, 8'h01);
        check("post-reset reg_wdata", reg_wdata, 8'hAB);
        dbg_check(8'h01, 8'hAB, "post-reset dbg 0x01");

        // Randomized transactions against the register model.
        for (int t = 0; t < 24; t++) begin
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                b[0] = 8'h42;
                if ($urandom_range(0, 5) == 0) begin
                    b[0] = 8'($urandom_range(0, 255)) & 8'hFE;
                    if (b[0][7:1] == 7'h21) b[0] = b[0] ^ 8'h80;
                end
                b[1] = 8'($urandom_range(0, 255));
                b[2] = 8'($urandom_range(0, 255));
                b[3] = 8'($urandom_range(0, 255));
                n    = $urandom_range(1, 4);
                write_txn(b, n, acks, wes);
                model_write(b, n, m_acks, m_wes);
                check($sformatf("rand%0d write acks", t), acks, m_acks);
                check($sformatf("rand%0d write we", t), wes, m_wes);
            end else begin
                if (kind == 1) begin
                    b[0] = 8'h42;
                    b[1] = 8'($urandom_range(0, 255));
                    write_txn(b, 2, acks, wes);
                    model_write(b, 2, m_acks, m_wes);
                    check($sformatf("rand%0d ptr acks", t), acks, m_acks);
                end
                exp_d = m_mem[m_ptr];
                read_txn(1'($urandom_range(0, 1)), a, d);
                check($sformatf("rand%0d read ack", t), a, 1);
                check($sformatf("rand%0d read data", t), d, exp_d);
            end
        end
        check("final id_err", id_err, m_iderr);
        check("final busy", busy, 0);
        for (int i = 0; i < 256; i++) dbg_check(8'(i), m_mem[i], $sformatf("sweep 0x%02h", i));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
